// File: rtl/time_mgr_ctrl_if.sv
// Command handshake and timestep bus between the time manager and its
// clients (software/debug command side and the emulated dt requesters).
interface time_mgr_ctrl_if #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DT_WIDTH   = 27,
  parameter int unsigned TIME_WIDTH = 39
);
  localparam int unsigned WIN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ*DT_WIDTH-1:0] dt_req;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [TIME_WIDTH-1:0]     cmd_arg;
  logic [DT_WIDTH-1:0]       emu_dt;
  logic [DT_WIDTH-1:0]       neg_emu_dt;
  logic [TIME_WIDTH-1:0]     emu_time;
  logic [WIN_W-1:0]          winner;
  logic                      stalled;

  modport master (
    output dt_req, cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, emu_dt, neg_emu_dt, emu_time, winner, stalled
  );

  modport slave (
    input  dt_req, cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, emu_dt, neg_emu_dt, emu_time, winner, stalled
  );
endinterface

// File: rtl/time_mgr_ctrl.sv
// Emulation time manager: arbitrates dt requests to a common emu_dt and keeps
// the running emu_time, under run / pause / single-step / run-until control.
module time_mgr_ctrl #(
  parameter int unsigned        N_REQ      = 2,
  parameter int unsigned        DT_WIDTH   = 27,
  parameter int unsigned        TIME_WIDTH = 39,
  parameter logic [DT_WIDTH-1:0] DT_MAX    = '1
) (
  input  logic           emu_clk,
  input  logic           emu_rst,
  time_mgr_ctrl_if.slave bus
);
  localparam int unsigned WIN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_UNTIL  = 2'd3;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_PAUSE = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_UNTIL = 2'd3;

  logic [1:0]            state_q, state_n;
  logic [TIME_WIDTH-1:0] stop_q, stop_n;
  logic [DT_WIDTH-1:0]   emu_dt_q, neg_dt_q;
  logic [TIME_WIDTH-1:0] emu_time_q;
  logic [WIN_W-1:0]      winner_q;
  logic                  stalled_q;

  logic [DT_WIDTH-1:0]   min_req;
  logic [WIN_W-1:0]      min_idx;
  logic [TIME_WIDTH-1:0] rem;
  logic [DT_WIDTH-1:0]   rem_c;
  logic [DT_WIDTH-1:0]   dt_n;
  logic [WIN_W-1:0]      win_n;
  logic [TIME_WIDTH-1:0] time_n;
  logic                  cmd_ready;
  logic                  cmd_acc;

  assign cmd_ready = (state_q != ST_STEP);
  assign cmd_acc   = bus.cmd_valid && cmd_ready;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_req = bus.dt_req[DT_WIDTH-1:0];
    min_idx = '0;
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (bus.dt_req[k*DT_WIDTH +: DT_WIDTH] < min_req) begin
        min_req = bus.dt_req[k*DT_WIDTH +: DT_WIDTH];
        min_idx = WIN_W'(k);
      end
    end
    if (min_req > DT_MAX) begin
      min_req = DT_MAX;
      min_idx = '0;
    end
  end

  // Distance to the stop time is modular, so a stop below emu_time runs across the wrap.
  always_comb begin
    rem   = stop_q - emu_time_q;
    rem_c = (rem > TIME_WIDTH'(DT_MAX)) ? DT_MAX : rem[DT_WIDTH-1:0];
  end

  always_comb begin
    dt_n  = '0;
    win_n = '0;
    case (state_q)
      ST_RUN, ST_STEP: begin
        dt_n  = min_req;
        win_n = min_idx;
      end
      ST_UNTIL: begin
        if (rem_c < min_req) begin
          dt_n  = rem_c;
          win_n = '0;
        end else begin
          dt_n  = min_req;
          win_n = min_idx;
        end
      end
      default: begin
        dt_n  = '0;
        win_n = '0;
      end
    endcase
    time_n = emu_time_q + TIME_WIDTH'(dt_n);
  end

  always_comb begin
    state_n = state_q;
    stop_n  = stop_q;
    case (state_q)
      ST_STEP:  state_n = ST_PAUSED;
      ST_UNTIL: if (time_n == stop_q) state_n = ST_PAUSED;
      default:  state_n = state_q;
    endcase
    if (cmd_acc) begin
      case (bus.cmd_op)
        OP_RUN:   state_n = ST_RUN;
        OP_PAUSE: state_n = ST_PAUSED;
        OP_STEP:  state_n = (state_q == ST_PAUSED) ? ST_STEP : ST_PAUSED;
        OP_UNTIL: begin
          stop_n  = bus.cmd_arg;
          state_n = (bus.cmd_arg == emu_time_q) ? ST_PAUSED : ST_UNTIL;
        end
        default:  state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q    <= ST_PAUSED;
      stop_q     <= '0;
      emu_dt_q   <= '0;
      neg_dt_q   <= '0;
      emu_time_q <= '0;
      winner_q   <= '0;
      stalled_q  <= 1'b1;
    end else begin
      state_q    <= state_n;
      stop_q     <= stop_n;
      emu_dt_q   <= dt_n;
      neg_dt_q   <= '0 - dt_n;
      emu_time_q <= time_n;
      winner_q   <= win_n;
      stalled_q  <= (state_n == ST_PAUSED);
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.emu_dt     = emu_dt_q;
  assign bus.neg_emu_dt = neg_dt_q;
  assign bus.emu_time   = emu_time_q;
  assign bus.winner     = winner_q;
  assign bus.stalled    = stalled_q;
endmodule

// File: tb/tb_time_mgr_ctrl.sv
// Directed bench for time_mgr_ctrl: expected outputs are queued as stimulus
// is applied and checked one edge later.
module tb_time_mgr_ctrl;
  localparam logic [1:0]  OP_RUN   = 2'd0;
  localparam logic [1:0]  OP_PAUSE = 2'd1;
  localparam logic [1:0]  OP_STEP  = 2'd2;
  localparam logic [1:0]  OP_UNTIL = 2'd3;
  localparam logic [38:0] T_WRAP   = 39'h7F_FFFF_FFEC;
  localparam logic [26:0] DT_ONES  = 27'h7FF_FFFF;

  typedef struct {
    string       tag;
    logic [26:0] dt;
    logic [38:0] tm;
    logic        win;
    logic        st;
  } exp_t;

  logic emu_clk;
  logic emu_rst;
  int   tests;
  int   fails;
  exp_t sb[$];

  time_mgr_ctrl_if #(.N_REQ(2), .DT_WIDTH(27), .TIME_WIDTH(39)) bus ();

  time_mgr_ctrl #(
    .N_REQ     (2),
    .DT_WIDTH  (27),
    .TIME_WIDTH(39)
  ) dut (
    .emu_clk(emu_clk),
    .emu_rst(emu_rst),
    .bus    (bus)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_next(input string tag, input logic [26:0] dt, input logic [38:0] tm,
                             input logic win, input logic st);
    exp_t e;
    logic [26:0] neg;
    sb.push_back('{tag, dt, tm, win, st});
    @(posedge emu_clk);
    #1;
    e   = sb.pop_front();
    neg = 27'd0 - e.dt;
    chk({e.tag, ".emu_dt"},     64'(bus.emu_dt),     64'(e.dt));
    chk({e.tag, ".neg_emu_dt"}, 64'(bus.neg_emu_dt), 64'(neg));
    chk({e.tag, ".emu_time"},   64'(bus.emu_time),   64'(e.tm));
    chk({e.tag, ".winner"},     64'(bus.winner),     64'(e.win));
    chk({e.tag, ".stalled"},    64'(bus.stalled),    64'(e.st));
  endtask

  task automatic send_cmd(input string tag, input logic [1:0] op, input logic [38:0] arg);
    chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(posedge emu_clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic set_req(input logic [26:0] k0, input logic [26:0] k1);
    bus.dt_req = {k1, k0};
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    emu_rst       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_RUN;
    bus.cmd_arg   = '0;
    set_req(27'd100, 27'd40);
    @(posedge emu_clk);
    expect_next("reset", 27'd0, 39'd0, 1'b0, 1'b1);
    chk("reset.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    emu_rst = 1'b0;

    // Run: min of {100, 40} is requester 1
    send_cmd("run", OP_RUN, '0);
    expect_next("run1", 27'd40, 39'd40, 1'b1, 1'b0);
    expect_next("run2", 27'd40, 39'd80, 1'b1, 1'b0);
    expect_next("run3", 27'd40, 39'd120, 1'b1, 1'b0);

    // Tie goes to requester 0; zero request freezes time but stays in RUN
    set_req(27'd50, 27'd50);
    expect_next("tie", 27'd50, 39'd170, 1'b0, 1'b0);
    set_req(27'd0, 27'd50);
    expect_next("zero1", 27'd0, 39'd170, 1'b0, 1'b0);
    expect_next("zero2", 27'd0, 39'd170, 1'b0, 1'b0);

    // Reset mid-RUN wins over a simultaneous RUN command
    set_req(27'd100, 27'd40);
    emu_rst       = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RUN;
    expect_next("rst_mid", 27'd0, 39'd0, 1'b0, 1'b1);
    chk("rst_mid.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    emu_rst       = 1'b0;
    bus.cmd_valid = 1'b0;
    expect_next("post_rst", 27'd0, 39'd0, 1'b0, 1'b1);

    // Single step
    set_req(27'd30, 27'd70);
    send_cmd("step", OP_STEP, '0);
    chk("step.busy_ready", 64'(bus.cmd_ready), 64'd0);
    chk("step.busy_stalled", 64'(bus.stalled), 64'd0);
    expect_next("step_pulse", 27'd30, 39'd30, 1'b0, 1'b1);
    chk("step.done_ready", 64'(bus.cmd_ready), 64'd1);
    expect_next("step_idle", 27'd0, 39'd30, 1'b0, 1'b1);

    // Run-until 250 with 100-unit requests
    emu_rst = 1'b1;
    expect_next("rst2", 27'd0, 39'd0, 1'b0, 1'b1);
    emu_rst = 1'b0;
    set_req(27'd100, 27'd100);
    send_cmd("until", OP_UNTIL, 39'd250);
    expect_next("until1", 27'd100, 39'd100, 1'b0, 1'b0);
    expect_next("until2", 27'd100, 39'd200, 1'b0, 1'b0);
    expect_next("until3", 27'd50, 39'd250, 1'b0, 1'b1);
    expect_next("until_idle", 27'd0, 39'd250, 1'b0, 1'b1);

    // Until to the current time pauses without stepping
    send_cmd("until_eq", OP_UNTIL, 39'd250);
    expect_next("until_eq1", 27'd0, 39'd250, 1'b0, 1'b1);
    expect_next("until_eq2", 27'd0, 39'd250, 1'b0, 1'b1);

    // STEP while running pauses instead of stepping
    send_cmd("run_b", OP_RUN, '0);
    send_cmd("step_in_run", OP_STEP, '0);
    expect_next("step_in_run", 27'd0, 39'd350, 1'b0, 1'b1);

    // Drive time up to just below the wrap point at full-scale steps
    set_req(DT_ONES, DT_ONES);
    send_cmd("until_far", OP_UNTIL, T_WRAP);
    n = 0;
    while (bus.stalled !== 1'b1 && n < 10000) begin
      @(posedge emu_clk);
      #1;
      n++;
    end
    chk("until_far.in_budget", 64'(n < 10000), 64'd1);
    chk("until_far.emu_time", 64'(bus.emu_time), 64'(T_WRAP));
    expect_next("until_far_idle", 27'd0, T_WRAP, 1'b0, 1'b1);

    // Stop time across the wrap: a single 50-unit step
    set_req(27'd100, 27'd100);
    send_cmd("until_wrap", OP_UNTIL, 39'd30);
    expect_next("until_wrap", 27'd50, 39'd30, 1'b0, 1'b1);
    expect_next("until_wrap_idle", 27'd0, 39'd30, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
